// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the width of the step counter.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, try to subtract the divisor, keep the difference only if it
// did not go negative.
module seq_restoring_divider_div_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder is below 2*divisor, so a non-negative trial fits in
  // WIDTH bits and a negative one is no smaller than -(2^WIDTH-1); the extra
  // msb of the WIDTH+1 bit trial is therefore exactly its sign.
  always_comb begin
    shifted      = {rem_in, dividend_bit};
    trial        = shifted - {1'b0, divisor};
    quotient_bit = ~trial[WIDTH];
    if (quotient_bit) begin
      rem_out = trial[WIDTH-1:0];
    end else begin
      rem_out = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider with a start/done handshake.
// One quotient bit per cycle; results are registered on entry to FIN and
// held until the next FIN or reset.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; operands captured when start is accepted
//   ST_CALC | one restoring step per cycle, count_q steps remaining
//   ST_FIN  | done pulse, results valid on the outputs, busy still high
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = count_width(WIDTH);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             accept;
  logic             last_step;

  // quo_q starts as the dividend; its msb feeds the step while quotient bits
  // shift in from the bottom, so after WIDTH steps it holds the quotient.
  seq_restoring_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_q),
    .dividend_bit(quo_q[WIDTH-1]),
    .divisor     (div_q),
    .rem_out     (step_rem),
    .quotient_bit(step_qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (divisor == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (count_q == CNT_W'(1)) begin
          last_step = 1'b1;
          state_d   = ST_FIN;
        end
      end
      ST_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand capture and iterative shift/subtract datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
    end else if (accept) begin
      count_q <= CNT_W'(WIDTH);
      rem_q   <= '0;
      quo_q   <= dividend;
      div_q   <= divisor;
    end else if (state_q == ST_CALC) begin
      count_q <= count_q - CNT_W'(1);
      rem_q   <= step_rem;
      quo_q   <= {quo_q[WIDTH-2:0], step_qbit};
    end
  end

  // Result registers, loaded only on the edge that enters FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && (divisor == '0)) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quotient    <= {quo_q[WIDTH-2:0], step_qbit};
      remainder   <= step_rem;
      div_by_zero <= 1'b0;
    end
  end

endmodule
